serial_frame_tx: RTL and testbench

Serial frame transmitter that produces the bit stream consumed by the team's serial frame receiver. On a `start` request it emits a fixed start pattern, an 8-bit payload length L, then L payload bits, all MSB first, one bit per clock. Payload bytes are pulled from a byte-wide ready/valid source. The block sits between a host/byte FIFO and the single-wire serial link.

---
 rtl/serial_frame_pkg.sv | 16 +
 rtl/piso_shift.sv | 27 ++
 rtl/serial_frame_tx.sv | 212 +++++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame transmitter.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSendStart,
        StSendLen,
        StSendData
    } tx_state_t;

    localparam int unsigned START_W_DEF = 4;
    localparam logic [START_W_DEF-1:0] START_PAT_DEF = 4'b1101;
    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out shift register; load wins over shift, zeros shift in at the LSB.
module piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift_en) begin
            sr_q <= {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start pattern, length field, then payload bits, all MSB first.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned              START_W   = START_W_DEF,
    parameter logic [START_W-1:0]       START_PAT = START_PAT_DEF,
    parameter int unsigned              LEN_W     = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ser_out,
    output logic              ser_out_valid,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam logic [LEN_W-1:0] START_LAST = LEN_W'(START_W - 1);
    localparam logic [LEN_W-1:0] LEN_LAST   = LEN_W'(LEN_W - 1);

    tx_state_t state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_nxt;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fetch_q, fetch_d, fetch_after, fetch_init;
    logic [LEN_W:0]     len_round;
    logic [START_W-1:0] pat_q, pat_d;
    logic [BYTE_W-1:0]  buf_q, buf_d;
    logic               full_q, full_d;
    logic ser_q, ser_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d, und_q, und_d;
    logic               hs, group, skip;
    logic               len_load, len_shift, len_msb;
    logic               dat_load, dat_shift, dat_msb;
    logic [BYTE_W-1:0]  dat_din;

    piso_shift #(.WIDTH(LEN_W)) u_len_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (len_load),
        .shift_en (len_shift),
        .din      (len),
        .msb      (len_msb)
    );

    piso_shift #(.WIDTH(BYTE_W)) u_dat_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (dat_load),
        .shift_en (dat_shift),
        .din      (dat_din),
        .msb      (dat_msb)
    );

    assign din_ready  = (state_q != StIdle) && !full_q && (fetch_q != '0);
    assign hs         = din_valid && din_ready;
    assign len_round  = {1'b0, len} + (LEN_W+1)'(BYTE_W - 1);
    assign fetch_init = LEN_W'(len_round >> 3);
    assign cnt_nxt    = cnt_q + LEN_W'(1);

    // ser_d is the bit shown in the next cycle; shifters advance as their bit is taken.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        pat_d     = pat_q;
        buf_d     = buf_q;
        full_d    = full_q;
        ser_d     = 1'b0;
        done_d    = 1'b0;
        und_d     = 1'b0;
        group     = 1'b0;
        skip      = 1'b0;
        len_load  = 1'b0;
        len_shift = 1'b0;
        dat_load  = 1'b0;
        dat_shift = 1'b0;
        dat_din   = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSendStart;
                    cnt_d    = '0;
                    len_d    = len;
                    full_d   = 1'b0;
                    len_load = 1'b1;
                    ser_d    = START_PAT[START_W-1];
                    pat_d    = START_PAT << 1;
                end
            end
            StSendStart: begin
                if (cnt_q == START_LAST) begin
                    state_d = StSendLen;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_nxt;
                end
                if (cnt_q == START_LAST) begin
                    ser_d     = len_msb;
                    len_shift = 1'b1;
                end else begin
                    ser_d = pat_q[START_W-1];
                    pat_d = pat_q << 1;
                end
            end
            StSendLen: begin
                if (cnt_q == LEN_LAST) begin
                    cnt_d = '0;
                    if (len_q != '0) begin
                        state_d = StSendData;
                        group   = 1'b1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d     = cnt_nxt;
                    ser_d     = len_msb;
                    len_shift = 1'b1;
                end
            end
            StSendData: begin
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_nxt;
                    if (cnt_nxt[2:0] == 3'd0) begin
                        group = 1'b1;
                    end else begin
                        ser_d     = dat_msb;
                        dat_shift = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (hs) begin
            buf_d  = din;
            full_d = 1'b1;
        end

        if (group) begin
            dat_load = 1'b1;
            if (full_q) begin
                ser_d   = buf_q[BYTE_W-1];
                dat_din = {buf_q[BYTE_W-2:0], 1'b0};
                full_d  = 1'b0;
            end else begin
                // Missing byte: send zeros and consume its fetch slot.
                und_d = 1'b1;
                skip  = 1'b1;
            end
        end

        fetch_after = fetch_q - LEN_W'(hs);
        if (skip && fetch_after != '0) begin
            fetch_after = fetch_after - LEN_W'(1);
        end
        if (state_q == StIdle) begin
            fetch_d = start ? fetch_init : fetch_q;
        end else begin
            fetch_d = fetch_after;
        end

        busy_d  = (state_d != StIdle);
        valid_d = (state_d == StSendData);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            fetch_q <= '0;
            pat_q   <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
            ser_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fetch_q <= fetch_d;
            pat_q   <= pat_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            ser_q   <= ser_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            und_q   <= und_d;
        end
    end

    assign ser_out       = ser_q;
    assign ser_out_valid = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign underrun      = und_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: expected per-cycle outputs queued at stimulus time.
module tb_serial_frame_tx;
    import serial_frame_pkg::*;

    localparam logic [3:0] PAT = 4'b1101;

    logic       clk = 1'b0;
    logic       rst, start, din_valid, din_ready;
    logic       ser_out, ser_out_valid, busy, done, underrun;
    logic [7:0] len;
    logic [7:0] din;

    // Per-cycle vector: {ser_out, ser_out_valid, underrun, busy, done}
    logic [4:0] exp_q[$];
    logic [7:0] src_q[$];
    logic       src_en;
    bit         rdy_seen;
    int         total = 0;
    int         bad   = 0;
    int         n_hs  = 0;

    serial_frame_tx dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .busy          (busy),
        .done          (done),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic s, input logic v, input logic u,
                                 input logic b, input logic d);
        exp_q.push_back({s, v, u, b, d});
    endfunction

    task automatic drive_src();
        din_valid = src_en && (src_q.size() != 0);
        din       = (src_q.size() != 0) ? src_q[0] : 8'h00;
    endtask

    // Advance one cycle: record handshake, refresh source, compare against scoreboard.
    task automatic tick(input string tag);
        logic       hs;
        logic [4:0] e;
        hs = din_valid && din_ready;
        if (din_ready) rdy_seen = 1'b1;
        @(negedge clk);
        if (hs) begin
            void'(src_q.pop_front());
            n_hs++;
        end
        drive_src();
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, 32'({ser_out, ser_out_valid, underrun, busy, done}), 32'(e));
        end
    endtask

    task automatic run_frame(input string name, input int l, input int pulse_at,
                             input int rst_at, input int exp_hs);
        logic [7:0] bytes[$];
        logic [7:0] lv;
        int         n, j, g, b, cyc;
        logic       d, u;
        bytes    = src_q;
        lv       = 8'(l);
        n        = (rst_at != 0) ? rst_at : 12 + l;
        n_hs     = 0;
        rdy_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i < 4) begin
                push(PAT[3-i], 1'b0, 1'b0, 1'b1, 1'b0);
            end else if (i < 12) begin
                push(lv[11-i], 1'b0, 1'b0, 1'b1, 1'b0);
            end else begin
                j = i - 12;
                g = j / 8;
                b = j % 8;
                if (src_en && g < bytes.size()) begin
                    d = bytes[g][7-b];
                    u = 1'b0;
                end else begin
                    d = 1'b0;
                    u = (b == 0);
                end
                push(d, 1'b1, u, 1'b1, 1'b0);
            end
        end
        if (rst_at == 0) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        drive_src();
        start = 1'b1;
        len   = lv;
        tick($sformatf("%s_c1", name));
        cyc = 1;
        while (exp_q.size() != 0) begin
            start = (cyc == pulse_at);
            rst   = (cyc == rst_at);
            len   = 8'($urandom);
            tick($sformatf("%s_c%0d", name, cyc + 1));
            cyc++;
        end
        start = 1'b0;
        rst   = 1'b0;
        chk($sformatf("%s_hs", name), 32'(n_hs), 32'(exp_hs));
        if (rst_at != 0) chk($sformatf("%s_rdy", name), 32'(din_ready), 32'(0));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        din       = '0;
        din_valid = 1'b0;
        src_en    = 1'b0;
        @(negedge clk);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("reset");
        chk("reset_rdy", 32'(din_ready), 32'(0));
        rst = 1'b0;
        tick("reset_rel");

        src_en = 1'b1;
        src_q = '{8'hA5};
        run_frame("len3", 3, 0, 0, 1);

        src_q = '{8'h5A};
        run_frame("len0", 0, 0, 0, 0);
        chk("len0_rdy_seen", 32'(rdy_seen), 32'(0));
        src_q = {};

        src_q = '{8'hA5, 8'h3C};
        run_frame("len10", 10, 0, 0, 2);

        src_en = 1'b0;
        src_q = {};
        run_frame("len16_under", 16, 0, 0, 0);

        src_en = 1'b1;
        src_q = '{8'hC3};
        run_frame("rst_mid", 5, 0, 7, 1);
        src_q = {};

        src_q = '{8'h80};
        run_frame("len1", 1, 0, 0, 1);

        // start and rst together: reset must win
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        len   = 8'd4;
        start = 1'b1;
        rst   = 1'b1;
        tick("start_rst_a");
        start = 1'b0;
        rst   = 1'b0;
        tick("start_rst_b");
        tick("start_rst_c");

        src_q = '{8'hF0, 8'h99};
        run_frame("busy_start", 12, 6, 0, 2);

        src_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        run_frame("len20", 20, 0, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
